nand_target_model: RTL

Synthesizable ONFI-style NAND flash responder: the device end of the NAND bus that the UART-to-NAND bridge drives as host. It samples CE#/CLE/ALE/WE#/RE#/IO in the fabric clock domain and decodes a subset of commands: reset, read ID, read status, page read and page program. It drives IO and R/B# back from a small internal page array. It sits on the board-side pins of the NAND I/O tristate buffer, or directly on the host's io_write/io lines in simulation and loopback builds.

---
 rtl/nand_target_model.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/nand_target_model.sv
// nand_target_model: device side of an ONFI-style NAND bus.
// All pins are oversampled in the fabric clock domain. A small command
// decoder serves reset, read ID, read status, page read and page program
// out of an on-chip page array through a one-page buffer.
module nand_target_model #(
    parameter int          PAGE_BYTES  = 64,
    parameter int          NUM_PAGES   = 16,
    parameter logic [39:0] ID_BYTES    = 40'h00_0000_F1EC,
    parameter int          BUSY_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       cle,
    input  logic       ale,
    input  logic       we,
    input  logic       re,
    input  logic       wp,
    input  logic [7:0] io_in,
    output logic [7:0] io_out,
    output logic       io_drive_en,
    output logic       rb
);

    localparam int CW   = $clog2(PAGE_BYTES);
    localparam int RW   = $clog2(NUM_PAGES);
    localparam int CNTW = $clog2(PAGE_BYTES + BUSY_CYCLES + 1);
    localparam int BW   = 14;

    localparam logic [CNTW-1:0] XFER_LAST = CNTW'(PAGE_BYTES + BUSY_CYCLES - 1);
    localparam logic [CNTW-1:0] RST_LAST  = CNTW'(BUSY_CYCLES - 1);
    localparam logic [CNTW-1:0] COPY_END  = CNTW'(PAGE_BYTES);
    localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_ZERO  = CNTW'(0);
    localparam logic [CW-1:0]   COL_LAST  = CW'(PAGE_BYTES - 1);
    localparam logic [CW-1:0]   COL_ONE   = CW'(1);
    localparam logic [CW-1:0]   COL_ZERO  = CW'(0);

    // Idle pin levels: deselected, no latch enables, strobes high, unprotected.
    localparam logic [BW-1:0] BUS_IDLE = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00};

    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_STATUS  = 8'h70;
    localparam logic [7:0] CMD_READ_ID = 8'h90;
    localparam logic [7:0] CMD_READ    = 8'h00;
    localparam logic [7:0] CMD_READ_GO = 8'h30;
    localparam logic [7:0] CMD_PROG    = 8'h80;
    localparam logic [7:0] CMD_PROG_GO = 8'h10;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_DIN       = 4'd2,
        S_XFER_RD   = 4'd3,
        S_XFER_PG   = 4'd4,
        S_RST_BUSY  = 4'd5,
        S_DOUT_ID   = 4'd6,
        S_DOUT_DATA = 4'd7,
        S_DOUT_STAT = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ID   = 2'd1,
        OP_READ = 2'd2,
        OP_PROG = 2'd3
    } op_t;

    // Pin synchronizers and edge history
    logic [BW-1:0] bus_s;
    logic [BW-1:0] sync1_r;
    logic [BW-1:0] sync2_r;
    logic [2:0]    hist_r;     // {ce, we, re} one clock behind sync2_r

    logic       ce_s, cle_s, ale_s, we_s, re_s, wp_s;
    logic [7:0] io_s;
    logic       we_rise_s, cmd_s, adr_s, dat_s;
    logic       re_fall_s, re_rise_s, ce_rise_s;

    // Control state
    state_t          state_r, state_nx;
    op_t             op_r, op_nx;
    logic [1:0]      addr_cnt_r, addr_cnt_nx;
    logic [CW-1:0]   col_r, col_nx;
    logic [RW-1:0]   row_r, row_nx;
    logic [2:0]      id_ptr_r, id_ptr_nx;
    logic [CNTW-1:0] cnt_r, cnt_nx;
    logic            fail_r, fail_nx;
    logic            stat_r, stat_nx;      // status view requested while busy
    logic            prog_ok_r, prog_ok_nx;
    logic            fill_start_s, din_wr_s;

    // Buffer pre-fill bookkeeping
    logic                  fill_act_r;
    logic [CW-1:0]         fill_ptr_r;
    logic [PAGE_BYTES-1:0] dirty_r;        // bytes already written by the host

    // Outputs
    logic [7:0] io_out_r;
    logic       drive_r;
    logic       rb_r;

    // Datapath helpers
    logic            busy_s, busy_nx_s;
    logic [CNTW-1:0] last_cnt_s;
    logic [CW-1:0]   cnt_col_s;
    logic            rd_copy_s, pg_copy_s, fill_wr_s;
    logic            stat_view_s, dout_mode_s;
    logic [7:0]      status_s, id_byte_s, dout_byte_s;

    logic [7:0] page_buf [0:PAGE_BYTES-1];
    logic [7:0] mem      [0:NUM_PAGES*PAGE_BYTES-1];

    assign bus_s = {ce, cle, ale, we, re, wp, io_in};

    assign ce_s  = sync2_r[13];
    assign cle_s = sync2_r[12];
    assign ale_s = sync2_r[11];
    assign we_s  = sync2_r[10];
    assign re_s  = sync2_r[9];
    assign wp_s  = sync2_r[8];
    assign io_s  = sync2_r[7:0];

    assign we_rise_s = we_s & ~hist_r[1] & ~ce_s;
    assign cmd_s     = we_rise_s & cle_s & ~ale_s;
    assign adr_s     = we_rise_s & ale_s & ~cle_s;
    assign dat_s     = we_rise_s & ~ale_s & ~cle_s;
    assign re_fall_s = ~re_s & hist_r[0] & ~ce_s;
    assign re_rise_s = re_s & ~hist_r[0] & ~ce_s;
    assign ce_rise_s = ce_s & ~hist_r[2];

    assign busy_s     = (state_r == S_XFER_RD) | (state_r == S_XFER_PG) | (state_r == S_RST_BUSY);
    assign busy_nx_s  = (state_nx == S_XFER_RD) | (state_nx == S_XFER_PG) | (state_nx == S_RST_BUSY);
    assign last_cnt_s = (state_r == S_RST_BUSY) ? RST_LAST : XFER_LAST;
    assign cnt_col_s  = cnt_r[CW-1:0];
    assign rd_copy_s  = (state_r == S_XFER_RD) & (cnt_r < COPY_END);
    assign pg_copy_s  = (state_r == S_XFER_PG) & prog_ok_r & (cnt_r < COPY_END);
    assign fill_wr_s  = fill_act_r & (op_r == OP_PROG) & ~dirty_r[fill_ptr_r];

    assign stat_view_s = (state_r == S_DOUT_STAT) | (busy_s & stat_r);
    assign dout_mode_s = stat_view_s | (state_r == S_DOUT_ID) | (state_r == S_DOUT_DATA);
    assign status_s    = {wp_s, ~busy_s, ~busy_s, 4'b0000, fail_r};

    assign io_out      = io_out_r;
    assign io_drive_en = drive_r;
    assign rb          = rb_r;

    // Two-flop pin synchronizer plus edge history for the strobe pins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= BUS_IDLE;
            sync2_r <= BUS_IDLE;
            hist_r  <= 3'b111;
        end else begin
            sync1_r <= bus_s;
            sync2_r <= sync1_r;
            hist_r  <= {sync2_r[13], sync2_r[10], sync2_r[9]};
        end
    end

    // ID byte selected by the ID pointer, least significant byte first.
    always_comb begin
        case (id_ptr_r)
            3'd0:    id_byte_s = ID_BYTES[7:0];
            3'd1:    id_byte_s = ID_BYTES[15:8];
            3'd2:    id_byte_s = ID_BYTES[23:16];
            3'd3:    id_byte_s = ID_BYTES[31:24];
            3'd4:    id_byte_s = ID_BYTES[39:32];
            default: id_byte_s = ID_BYTES[7:0];
        endcase
    end

    // Byte presented on the next RE falling edge for the current output mode.
    always_comb begin
        if (stat_view_s) begin
            dout_byte_s = status_s;
        end else if (state_r == S_DOUT_ID) begin
            dout_byte_s = id_byte_s;
        end else if (state_r == S_DOUT_DATA) begin
            dout_byte_s = page_buf[col_r];
        end else begin
            dout_byte_s = io_out_r;
        end
    end

    // Next-state and control decode: busy sequencing, then bus events.
    always_comb begin
        state_nx     = state_r;
        op_nx        = op_r;
        addr_cnt_nx  = addr_cnt_r;
        col_nx       = col_r;
        row_nx       = row_r;
        id_ptr_nx    = id_ptr_r;
        cnt_nx       = cnt_r;
        fail_nx      = fail_r;
        stat_nx      = stat_r;
        prog_ok_nx   = prog_ok_r;
        fill_start_s = 1'b0;
        din_wr_s     = 1'b0;

        // Transfers run to completion on their own; deselect only idles the decoder.
        if (busy_s) begin
            if (cnt_r == last_cnt_s) begin
                cnt_nx  = CNT_ZERO;
                stat_nx = 1'b0;
                if (stat_r) begin
                    state_nx = S_DOUT_STAT;
                end else if (state_r == S_XFER_RD) begin
                    state_nx = S_DOUT_DATA;
                end else begin
                    state_nx = S_IDLE;
                end
            end else begin
                cnt_nx = cnt_r + CNT_ONE;
            end
        end else if (ce_rise_s) begin
            state_nx = S_IDLE;
            stat_nx  = 1'b0;
        end else begin
            state_nx = state_r;
        end

        if (cmd_s) begin
            if (io_s == CMD_RESET) begin
                state_nx = S_RST_BUSY;
                op_nx    = OP_NONE;
                cnt_nx   = CNT_ZERO;
                fail_nx  = 1'b0;
                stat_nx  = 1'b0;
            end else if (io_s == CMD_STATUS) begin
                if (busy_s) begin
                    stat_nx = 1'b1;
                end else begin
                    state_nx = S_DOUT_STAT;
                    stat_nx  = 1'b0;
                end
            end else if (!busy_s) begin
                case (io_s)
                    CMD_READ_ID: begin
                        state_nx    = S_ADDR;
                        op_nx       = OP_ID;
                        addr_cnt_nx = 2'd0;
                    end
                    CMD_READ: begin
                        state_nx    = S_ADDR;
                        op_nx       = OP_READ;
                        addr_cnt_nx = 2'd0;
                    end
                    CMD_READ_GO: begin
                        if ((state_r == S_ADDR) && (op_r == OP_READ) && (addr_cnt_r == 2'd2)) begin
                            state_nx = S_XFER_RD;
                            cnt_nx   = CNT_ZERO;
                        end else begin
                            state_nx = state_r;
                        end
                    end
                    CMD_PROG: begin
                        state_nx     = S_ADDR;
                        op_nx        = OP_PROG;
                        addr_cnt_nx  = 2'd0;
                        fill_start_s = 1'b1;
                    end
                    CMD_PROG_GO: begin
                        if (state_r == S_DIN) begin
                            state_nx   = S_XFER_PG;
                            cnt_nx     = CNT_ZERO;
                            prog_ok_nx = wp_s;
                            fail_nx    = fail_r | ~wp_s;
                        end else begin
                            state_nx = state_r;
                        end
                    end
                    default: state_nx = state_nx;
                endcase
            end else begin
                state_nx = state_nx;
            end
        end else if (adr_s) begin
            if (state_r == S_ADDR) begin
                if (op_r == OP_ID) begin
                    state_nx  = S_DOUT_ID;
                    id_ptr_nx = 3'd0;
                end else if (addr_cnt_r == 2'd0) begin
                    col_nx      = io_s[CW-1:0];
                    addr_cnt_nx = 2'd1;
                end else if (addr_cnt_r == 2'd1) begin
                    row_nx      = io_s[RW-1:0];
                    addr_cnt_nx = 2'd2;
                    if (op_r == OP_PROG) begin
                        state_nx = S_DIN;
                    end else begin
                        state_nx = state_r;
                    end
                end else begin
                    addr_cnt_nx = addr_cnt_r;
                end
            end else begin
                state_nx = state_nx;
            end
        end else if (dat_s) begin
            if (state_r == S_DIN) begin
                din_wr_s = 1'b1;
                col_nx   = col_r + COL_ONE;
            end else begin
                col_nx = col_r;
            end
        end else if (re_rise_s) begin
            if (state_r == S_DOUT_ID) begin
                id_ptr_nx = (id_ptr_r == 3'd4) ? 3'd0 : id_ptr_r + 3'd1;
            end else if (state_r == S_DOUT_DATA) begin
                col_nx = col_r + COL_ONE;
            end else begin
                col_nx = col_r;
            end
        end else begin
            col_nx = col_nx;
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= S_IDLE;
            op_r       <= OP_NONE;
            addr_cnt_r <= 2'd0;
            col_r      <= COL_ZERO;
            row_r      <= {RW{1'b0}};
            id_ptr_r   <= 3'd0;
            cnt_r      <= CNT_ZERO;
            fail_r     <= 1'b0;
            stat_r     <= 1'b0;
            prog_ok_r  <= 1'b0;
        end else begin
            state_r    <= state_nx;
            op_r       <= op_nx;
            addr_cnt_r <= addr_cnt_nx;
            col_r      <= col_nx;
            row_r      <= row_nx;
            id_ptr_r   <= id_ptr_nx;
            cnt_r      <= cnt_nx;
            fail_r     <= fail_nx;
            stat_r     <= stat_nx;
            prog_ok_r  <= prog_ok_nx;
        end
    end

    // 0xFF pre-fill walker; bytes the host already wrote are skipped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_act_r <= 1'b0;
            fill_ptr_r <= COL_ZERO;
            dirty_r    <= {PAGE_BYTES{1'b0}};
        end else if (fill_start_s) begin
            fill_act_r <= 1'b1;
            fill_ptr_r <= COL_ZERO;
            dirty_r    <= {PAGE_BYTES{1'b0}};
        end else begin
            if (din_wr_s) begin
                dirty_r[col_r] <= 1'b1;
            end
            if (fill_act_r) begin
                if ((op_r != OP_PROG) || (fill_ptr_r == COL_LAST)) begin
                    fill_act_r <= 1'b0;
                end else begin
                    fill_ptr_r <= fill_ptr_r + COL_ONE;
                end
            end
        end
    end

    // Page buffer and array storage; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (fill_wr_s) begin
            page_buf[fill_ptr_r] <= 8'hFF;
        end
        if (din_wr_s) begin
            page_buf[col_r] <= io_s;
        end
        if (rd_copy_s) begin
            page_buf[cnt_col_s] <= mem[{row_r, cnt_col_s}];
        end
        if (pg_copy_s) begin
            mem[{row_r, cnt_col_s}] <= page_buf[cnt_col_s];
        end
    end

    // Registered bus outputs; rb tracks the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            io_out_r <= 8'h00;
            drive_r  <= 1'b0;
            rb_r     <= 1'b1;
        end else begin
            if (re_fall_s && dout_mode_s) begin
                io_out_r <= dout_byte_s;
            end
            drive_r <= dout_mode_s & ~ce_s & ~re_s;
            rb_r    <= ~busy_nx_s;
        end
    end

endmodule
